alu_cmd_master: RTL
===================

# alu_cmd_master

Initiator for the ALU push/stop datapath port. It buffers operand commands from a host-side stream, issues them to the ALU, and applies credit-based flow control so that no result can overflow its result buffer. It optionally chains carry from the previous result into the next command for multi-byte arithmetic. Returned results are buffered and forwarded on a host-side result stream. The block sits between the test/host logic and the ALU DUT port.

## Interface
- CMD_DEPTH, 4: command FIFO entries (power of 2, ≥2)
- RES_DEPTH, 4: result FIFO entries (power of 2, ≥2); also the maximum number of commands issued but not yet drained
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-low
- cmd_push  input  1  host command valid
- cmd_stop  output  1  command FIFO full; host must hold
- cmd_ctl  input  2  ALU op (alu_pkg ctl encoding)
- cmd_a, cmd_b  input  8  operands
- cmd_ci  input  1  carry-in, used when cmd_chain=0
- cmd_chain  input  1  1 = use cout of the previous result as ci
- pushin  output  1  request valid to ALU
- stopout  input  1  ALU backpressure
- ctl  output  2  op to ALU
- a, b  output  8  operands to ALU
- ci  output  1  carry-in to ALU
- pushout  input  1  ALU result valid
- z  input  8  ALU result
- cout  input  1  ALU carry-out
- stopin  output  1  result FIFO full
- res_push  output  1  result valid to host
- res_stop  input  1  host backpressure
- res_z  output  8  buffered result
- res_cout  output  1  buffered carry
- outstanding  output  $clog2(RES_DEPTH)+1  issued commands not yet returned
- err  output  1  sticky: result received while outstanding==0

## Operation
- Command accept: cmd_push && !cmd_stop writes {ctl,a,b,ci,chain} into the command FIFO. cmd_stop = command FIFO full.
- Issue transfer: pushin && !stopout. pushin = command FIFO not empty && state==ISSUE && (outstanding + res_count) < RES_DEPTH. ctl/a/b/ci are driven directly from the command FIFO head, so there is no bubble.
- FSM:
  - ISSUE: if the head has chain=1 and outstanding≠0, go to WAIT_CHAIN and hold pushin=0.
  - WAIT_CHAIN: when outstanding==0 (including a return in the same cycle), go to ISSUE.
  - When chain=1, ci = last_cout. last_cout is updated on every result transfer (pushout && !stopin), is bypassed in the same cycle the result returns, and resets to 0.
- outstanding: +1 on an issue transfer, −1 on a result transfer; both in the same cycle leaves it unchanged. Credits guarantee it never exceeds RES_DEPTH.
- Result capture: a result transfer writes {z,cout} into the result FIFO. stopin = result FIFO full; by construction it never asserts under credit control.
- Result output: res_push = result FIFO not empty; a pop happens on res_push && !res_stop.
- err: set when pushout arrives with outstanding==0. That result is still stored if space allows. err is cleared only by rst.
- Reset, including mid-transaction: both FIFOs are emptied, the FSM returns to ISSUE, and the counters and last_cout go to 0. In-flight ALU results that arrive afterwards set err.

## Timing
- Reset values: cmd_stop=0, pushin=0, ctl=0, a=0, b=0, ci=0, stopin=0, res_push=0, res_z=0, res_cout=0, outstanding=0, err=0. Head-driven outputs are 0 when the FIFO is empty.
- Command push to pushin: 1 cycle (FIFO write registered; pushin asserts the next cycle).
- Result transfer to res_push: 1 cycle.
- The command FIFO supports a simultaneous push and pop when full: the pop frees space for the next cycle only, so cmd_stop stays registered-full that cycle.
- The result FIFO supports a simultaneous write and read.
- Pointers wrap modulo depth; full and empty use an extra pointer bit.

## Structure
- alu_pkg holds:
  - ctl constants CTL_ADD=2'b00, CTL_SUB=2'b01, CTL_AND=2'b10, CTL_OR=2'b11
  - the cmd_t struct {ctl,a,b,ci,chain}
  - the res_t struct {z,cout}
  - the state enum {ISSUE, WAIT_CHAIN}
- One sub-module, alu_sync_fifo (parameterised WIDTH and DEPTH, same clk/rst), is instantiated twice: command FIFO and result FIFO.

## Test plan
- Reset then single command: push ADD a=8'h12 b=8'h34 ci=0. pushin asserts 1 cycle later; ALU returns z=8'h46 cout=0; res_push 1 cycle after pushout; outstanding goes 0→1→0.
- Command backpressure: hold stopout=1 and push 5 commands. cmd_stop asserts after 4 accepted; pushin stays high with the head stable. Release stopout: all 4 issue on consecutive cycles.
- Credit limit: res_stop=1, 6 commands queued. Exactly 4 issue; pushin drops with outstanding + res_count = 4. stopin is never asserted. Release res_stop: the remaining 2 issue.
- Carry chain: ADD 8'hFF+8'h01 (chain=0), then ADD 8'h00+8'h00 (chain=1). The second command waits in WAIT_CHAIN until the first result (cout=1) returns, then issues with ci=1; result z=8'h01.
- Spurious result: pushout with outstanding=0 → err=1, stays 1 until rst.
- Mid-operation reset: 2 commands outstanding, assert rst for 1 cycle. All outputs return to reset values; the FIFOs empty; a later stray pushout sets err.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU command master: op encodings, command/result payloads, issue FSM states.
package alu_pkg;

    localparam int unsigned DATA_W = 8;

    localparam logic [1:0] CTL_ADD = 2'b00;
    localparam logic [1:0] CTL_SUB = 2'b01;
    localparam logic [1:0] CTL_AND = 2'b10;
    localparam logic [1:0] CTL_OR  = 2'b11;

    typedef struct packed {
        logic [1:0]        ctl;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              ci;
        logic              chain;
    } cmd_t;

    typedef struct packed {
        logic [DATA_W-1:0] z;
        logic              cout;
    } res_t;

    typedef enum logic {
        ISSUE      = 1'b0,
        WAIT_CHAIN = 1'b1
    } state_t;

endpackage

// File: rtl/alu_sync_fifo.sv
// Synchronous FIFO with extra-bit pointers; head data reads as zero when empty.
module alu_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             full;
    logic             empty;
    logic             do_wr;
    logic             do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;
    assign count = wr_ptr - rd_ptr;
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset: pointers define validity.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/alu_cmd_master.sv
// ALU initiator: buffers host commands, issues them under result-buffer credits, chains carry, returns results.
module alu_cmd_master
    import alu_pkg::*;
#(
    parameter int unsigned CMD_DEPTH = 4,
    parameter int unsigned RES_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_push,
    output logic                          cmd_stop,
    input  logic [1:0]                    cmd_ctl,
    input  logic [DATA_W-1:0]             cmd_a,
    input  logic [DATA_W-1:0]             cmd_b,
    input  logic                          cmd_ci,
    input  logic                          cmd_chain,
    output logic                          pushin,
    input  logic                          stopout,
    output logic [1:0]                    ctl,
    output logic [DATA_W-1:0]             a,
    output logic [DATA_W-1:0]             b,
    output logic                          ci,
    input  logic                          pushout,
    input  logic [DATA_W-1:0]             z,
    input  logic                          cout,
    output logic                          stopin,
    output logic                          res_push,
    input  logic                          res_stop,
    output logic [DATA_W-1:0]             res_z,
    output logic                          res_cout,
    output logic [$clog2(RES_DEPTH):0]    outstanding,
    output logic                          err
);

    localparam int unsigned CW = $clog2(CMD_DEPTH) + 1;
    localparam int unsigned OW = $clog2(RES_DEPTH) + 1;
    localparam int unsigned SW = OW + 1;

    cmd_t          cmd_in;
    cmd_t          head;
    res_t          res_in;
    res_t          res_head;
    logic [CW-1:0] cmd_count;
    logic [OW-1:0] res_count;
    logic          cmd_empty;
    logic          res_empty;
    logic          credit_ok;
    logic          chain_block;
    logic          issue;
    logic          res_xfer;
    logic          last_cout;
    state_t        state;
    state_t        state_next;

    assign cmd_in = '{ctl: cmd_ctl, a: cmd_a, b: cmd_b, ci: cmd_ci, chain: cmd_chain};
    assign res_in = '{z: z, cout: cout};

    alu_sync_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (cmd_push),
        .wr_data (cmd_in),
        .rd_en   (issue),
        .rd_data (head),
        .count   (cmd_count)
    );

    alu_sync_fifo #(.WIDTH($bits(res_t)), .DEPTH(RES_DEPTH)) u_res_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (res_xfer),
        .wr_data (res_in),
        .rd_en   (!res_stop),
        .rd_data (res_head),
        .count   (res_count)
    );

    assign cmd_empty   = (cmd_count == '0);
    assign cmd_stop    = (cmd_count == CW'(CMD_DEPTH));
    assign res_empty   = (res_count == '0);
    assign stopin      = (res_count == OW'(RES_DEPTH));
    assign res_push    = !res_empty;
    assign res_z       = res_head.z;
    assign res_cout    = res_head.cout;

    assign credit_ok   = (SW'(outstanding) + SW'(res_count)) < SW'(RES_DEPTH);
    assign chain_block = head.chain && (outstanding != '0);
    assign issue       = pushin && !stopout;
    assign res_xfer    = pushout && !stopin;

    // Head fields drive the ALU directly; chained carry bypasses a same-cycle return.
    assign ctl = head.ctl;
    assign a   = head.a;
    assign b   = head.b;
    assign ci  = head.chain ? (res_xfer ? cout : last_cout) : head.ci;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ISSUE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        pushin     = 1'b0;
        case (state)
            ISSUE: begin
                if (!cmd_empty && chain_block) state_next = WAIT_CHAIN;
                pushin = !cmd_empty && credit_ok && !chain_block;
            end
            WAIT_CHAIN: begin
                if ((outstanding == '0) || ((outstanding == OW'(1)) && res_xfer))
                    state_next = ISSUE;
            end
        endcase
    end

    // Outstanding count, carry history and sticky protocol error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outstanding <= '0;
            last_cout   <= 1'b0;
            err         <= 1'b0;
        end else begin
            case ({issue, res_xfer})
                2'b10:   outstanding <= outstanding + OW'(1);
                2'b01:   if (outstanding != '0) outstanding <= outstanding - OW'(1);
                default: outstanding <= outstanding;
            endcase
            if (res_xfer) last_cout <= cout;
            if (pushout && (outstanding == '0)) err <= 1'b1;
        end
    end

endmodule
